// File: rtl/array_fifo_ctrl_if.sv
// Handshake and array-port bundle between the FIFO controller, its producer/consumer and the register array.
// The slave modport is the controller side; master is the environment around it.
interface array_fifo_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             mem_write_en;
    logic [1:0]       mem_write_addr;
    logic [WIDTH-1:0] mem_write_data;
    logic [1:0]       mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;

    modport master (
        output in_valid, in_data, out_ready, mem_read_data,
        input  in_ready, out_valid, out_data,
               mem_write_en, mem_write_addr, mem_write_data, mem_read_addr
    );

    modport slave (
        input  in_valid, in_data, out_ready, mem_read_data,
        output in_ready, out_valid, out_data,
               mem_write_en, mem_write_addr, mem_write_data, mem_read_addr
    );
endinterface

// File: rtl/array_fifo_ctrl.sv
// Valid/ready FIFO controller in front of a 4-word register array.
// Owns pointers, occupancy and sticky error flags; the array only stores words.
module array_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    array_fifo_ctrl_if.slave        bus,
    output logic [2:0]              count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_STEP = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    // Extra MSB distinguishes full from empty when the address bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign bus.in_ready  = !full && !rst && !flush;
    assign bus.out_valid = !empty && !rst && !flush;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign bus.mem_write_en   = push;
    assign bus.mem_write_addr = wr_ptr[AW-1:0];
    assign bus.mem_write_data = bus.in_data;
    assign bus.mem_read_addr  = rd_ptr[AW-1:0];
    assign head               = bus.mem_read_data;
    assign bus.out_data       = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_STEP;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (bus.in_valid && full) begin
                overflow <= 1'b1;
            end
            if (bus.out_ready && empty) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_array_fifo_ctrl.sv
// Self-checking bench for array_fifo_ctrl: directed scenarios plus a randomized run against a queue model.
module tb_array_fifo_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    array_fifo_ctrl_if #(.WIDTH(8)) bus ();

    array_fifo_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the structural array: synchronous write, combinational read.
    logic [7:0] mem [4];
    always @(posedge clk) begin
        if (bus.mem_write_en === 1'b1) begin
            mem[bus.mem_write_addr] <= bus.mem_write_data;
        end
    end
    assign bus.mem_read_data = mem[bus.mem_read_addr];

    int passed = 0;
    int total  = 0;

    // Reference model: a queue of stored words, a running push tally for addresses, sticky flags.
    logic [7:0] q[$];
    int         m_wr  = 0;
    bit         m_ovf = 0;
    bit         m_udf = 0;

    logic       exp_in_ready;
    logic       exp_out_valid;
    logic       exp_wen;
    logic [2:0] exp_count;
    logic [1:0] exp_wr_addr;
    logic [1:0] exp_rd_addr;
    logic [7:0] exp_out_data;

    task automatic model_eval();
        exp_in_ready  = (q.size() < 4) && !rst && !flush;
        exp_out_valid = (q.size() > 0) && !rst && !flush;
        exp_wen       = bus.in_valid && exp_in_ready;
        exp_count     = 3'(q.size());
        exp_wr_addr   = 2'(m_wr % 4);
        exp_rd_addr   = 2'((m_wr - q.size()) % 4);
        exp_out_data  = (q.size() > 0) ? q[0] : 8'h00;
    endtask

    task automatic set_in(input bit iv, input logic [7:0] d, input bit ordy, input bit fl, input bit rs);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        rst           = rs;
        #1;
        model_eval();
    endtask

    task automatic tick();
        bit         c_rst, c_flush, c_iv, c_or, c_vld, c_wen;
        logic [7:0] c_d;
        c_rst = rst; c_flush = flush; c_iv = bus.in_valid; c_or = bus.out_ready;
        c_d = bus.in_data; c_vld = exp_out_valid; c_wen = exp_wen;
        @(posedge clk);
        if (c_rst) begin
            q.delete(); m_wr = 0; m_ovf = 0; m_udf = 0;
        end else if (c_flush) begin
            q.delete(); m_wr = 0;
        end else begin
            if (c_iv && q.size() == 4) m_ovf = 1;
            if (c_or && q.size() == 0) m_udf = 1;
            if (c_or && c_vld) void'(q.pop_front());
            if (c_wen) begin q.push_back(c_d); m_wr++; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        total++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset.in_ready got %b want 0", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset.out_valid got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.mem_write_en !== 1'b0) $display("[TB] FAIL reset.wen got %b want 0", bus.mem_write_en); else passed++;
        tick();
        set_in(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL post_reset.in_ready got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL post_reset.out_valid got %b want 0", bus.out_valid); else passed++;
        total++; if (count !== 3'd0) $display("[TB] FAIL post_reset.count got %0d want 0", count); else passed++;
        total++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL post_reset.flags got %b want 00", {overflow, underflow}); else passed++;
        total++; if ({bus.mem_write_en, bus.mem_write_addr, bus.mem_read_addr} !== 5'b0) $display("[TB] FAIL post_reset.mem got %b want 00000", {bus.mem_write_en, bus.mem_write_addr, bus.mem_read_addr}); else passed++;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals = '{8'h00, 8'h33, 8'h66, 8'h99};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
            total++; if (bus.mem_write_en !== 1'b1) $display("[TB] FAIL fill.wen[%0d] got %b want 1", i, bus.mem_write_en); else passed++;
            total++; if (bus.mem_write_addr !== 2'(i)) $display("[TB] FAIL fill.waddr[%0d] got %0d want %0d", i, bus.mem_write_addr, i); else passed++;
            total++; if (count !== 3'(i)) $display("[TB] FAIL fill.count[%0d] got %0d want %0d", i, count, i); else passed++;
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 3'd4) $display("[TB] FAIL full.count got %0d want 4", count); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL full.in_ready got %b want 0", bus.in_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            total++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL drain.out_valid[%0d] got %b want 1", i, bus.out_valid); else passed++;
            total++; if (bus.out_data !== vals[i]) $display("[TB] FAIL drain.data[%0d] got %h want %h", i, bus.out_data, vals[i]); else passed++;
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 3'd0) $display("[TB] FAIL drained.count got %0d want 0", count); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL drained.out_valid got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        total++; if (bus.mem_write_en !== 1'b0) $display("[TB] FAIL ovf.wen got %b want 0", bus.mem_write_en); else passed++;
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 3'd4) $display("[TB] FAIL ovf.count got %0d want 4", count); else passed++;
        total++; if (overflow !== 1'b1) $display("[TB] FAIL ovf.flag got %b want 1", overflow); else passed++;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            total++; if (bus.out_data !== exp_out_data) $display("[TB] FAIL ovf.drain[%0d] got %h want %h", i, bus.out_data, exp_out_data); else passed++;
            tick();
        end
        set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        total++; if (underflow !== 1'b0) $display("[TB] FAIL udf.early got %b want 0", underflow); else passed++;
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        total++; if (underflow !== 1'b1) $display("[TB] FAIL udf.flag got %b want 1", underflow); else passed++;
        total++; if (overflow !== 1'b1) $display("[TB] FAIL ovf.sticky got %b want 1", overflow); else passed++;
    endtask

    task automatic test_wrap();
        set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 8'(8'h10 + i), i > 0, 1'b0, 1'b0);
            total++; if (bus.mem_write_addr !== 2'(i % 4)) $display("[TB] FAIL wrap.waddr[%0d] got %0d want %0d", i, bus.mem_write_addr, i % 4); else passed++;
            if (i > 0) begin
                total++; if (count !== 3'd1) $display("[TB] FAIL wrap.count[%0d] got %0d want 1", i, count); else passed++;
                total++; if (bus.out_data !== 8'(8'h10 + i - 1)) $display("[TB] FAIL wrap.data[%0d] got %h want %h", i, bus.out_data, 8'(8'h10 + i - 1)); else passed++;
            end
            tick();
        end
        set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        total++; if (bus.out_data !== 8'h19) $display("[TB] FAIL wrap.last got %h want 19", bus.out_data); else passed++;
        tick();
    endtask

    task automatic test_flush();
        set_in(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, 8'h22, 1'b0, 1'b0, 1'b0); tick();
        set_in(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
        total++; if ({bus.in_ready, bus.out_valid, bus.mem_write_en} !== 3'b000) $display("[TB] FAIL flush.void got %b want 000", {bus.in_ready, bus.out_valid, bus.mem_write_en}); else passed++;
        tick();
        set_in(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 3'd0) $display("[TB] FAIL flush.count got %0d want 0", count); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL flush.out_valid got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.mem_write_addr !== 2'd0) $display("[TB] FAIL flush.waddr got %0d want 0", bus.mem_write_addr); else passed++;
        tick();
        set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        total++; if (bus.out_data !== 8'h44) $display("[TB] FAIL flush.data got %h want 44", bus.out_data); else passed++;
        tick();
    endtask

    task automatic test_full_pop();
        logic [7:0] want [4];
        logic [1:0] freed;
        want = '{8'hA1, 8'hA2, 8'hA3, 8'hB5};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 8'hB5, 1'b1, 1'b0, 1'b0);
        freed = exp_rd_addr;
        total++; if (bus.mem_write_en !== 1'b0) $display("[TB] FAIL fullpop.wen got %b want 0", bus.mem_write_en); else passed++;
        total++; if (bus.out_data !== 8'hA0) $display("[TB] FAIL fullpop.data got %h want a0", bus.out_data); else passed++;
        tick();
        set_in(1'b1, 8'hB5, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 3'd3) $display("[TB] FAIL fullpop.count got %0d want 3", count); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL fullpop.in_ready got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.mem_write_addr !== freed) $display("[TB] FAIL fullpop.waddr got %0d want %0d", bus.mem_write_addr, freed); else passed++;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            total++; if (bus.out_data !== want[i]) $display("[TB] FAIL fullpop.drain[%0d] got %h want %h", i, bus.out_data, want[i]); else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(9, 0) < 7, 8'($urandom), $urandom_range(9, 0) < 6,
                   $urandom_range(31, 0) == 0, $urandom_range(63, 0) == 0);
            total++; if (bus.in_ready !== exp_in_ready) $display("[TB] FAIL rnd.in_ready[%0d] got %b want %b", i, bus.in_ready, exp_in_ready); else passed++;
            total++; if (bus.out_valid !== exp_out_valid) $display("[TB] FAIL rnd.out_valid[%0d] got %b want %b", i, bus.out_valid, exp_out_valid); else passed++;
            total++; if (bus.mem_write_en !== exp_wen) $display("[TB] FAIL rnd.wen[%0d] got %b want %b", i, bus.mem_write_en, exp_wen); else passed++;
            total++; if (count !== exp_count) $display("[TB] FAIL rnd.count[%0d] got %0d want %0d", i, count, exp_count); else passed++;
            total++; if ({overflow, underflow} !== {m_ovf, m_udf}) $display("[TB] FAIL rnd.flags[%0d] got %b want %b", i, {overflow, underflow}, {m_ovf, m_udf}); else passed++;
            total++; if ({bus.mem_write_addr, bus.mem_read_addr} !== {exp_wr_addr, exp_rd_addr}) $display("[TB] FAIL rnd.addr[%0d] got %b want %b", i, {bus.mem_write_addr, bus.mem_read_addr}, {exp_wr_addr, exp_rd_addr}); else passed++;
            if (exp_out_valid) begin
                total++; if (bus.out_data !== exp_out_data) $display("[TB] FAIL rnd.data[%0d] got %h want %h", i, bus.out_data, exp_out_data); else passed++;
            end
            if (exp_wen) begin
                total++; if (bus.mem_write_data !== bus.in_data) $display("[TB] FAIL rnd.wdata[%0d] got %h want %h", i, bus.mem_write_data, bus.in_data); else passed++;
            end
            tick();
        end
    endtask

    initial begin
        $display("[TB] array_fifo_ctrl bench start");
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_wrap();
        test_flush();
        test_full_pop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
